// File: rtl/dot_product_sequencer_pkg.sv
// rtl/dot_product_sequencer_pkg.sv - shared types and default widths for the dot-product sequencer
package dot_product_sequencer_pkg;

    localparam int DPS_INPUT_LENGTH  = 32;
    localparam int DPS_OUTPUT_LENGTH = 64;
    localparam int DPS_LEN_WIDTH     = 16;
    localparam int DPS_FIFO_DEPTH    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_RET,
        ST_WAIT,
        ST_HOLD
    } state_e;

    typedef logic [DPS_LEN_WIDTH-1:0] len_t;

endpackage

// File: rtl/dot_product_sequencer_if.sv
// rtl/dot_product_sequencer_if.sv - job, operand, MAC and result signals of the sequencer
interface dot_product_sequencer_if #(
    parameter int INPUT_LENGTH  = 32,
    parameter int OUTPUT_LENGTH = 64,
    parameter int LEN_WIDTH     = 16
);
    logic                     iStart;
    logic [LEN_WIDTH-1:0]     iLen;
    logic                     oBusy;
    logic                     iOpValid;
    logic [INPUT_LENGTH-1:0]  iOpA;
    logic [INPUT_LENGTH-1:0]  iOpB;
    logic                     oOpReady;
    logic [INPUT_LENGTH-1:0]  oMacA;
    logic [INPUT_LENGTH-1:0]  oMacB;
    logic                     oMAC;
    logic                     oRET;
    logic                     iMacReady;
    logic [OUTPUT_LENGTH-1:0] iMacRes;
    logic                     iMacDone;
    logic                     oResValid;
    logic [OUTPUT_LENGTH-1:0] oRes;
    logic                     iResReady;

    modport master (
        input  iStart, iLen, iOpValid, iOpA, iOpB, iMacReady, iMacRes, iMacDone, iResReady,
        output oBusy, oOpReady, oMacA, oMacB, oMAC, oRET, oResValid, oRes
    );

    modport slave (
        output iStart, iLen, iOpValid, iOpA, iOpB, iMacReady, iMacRes, iMacDone, iResReady,
        input  oBusy, oOpReady, oMacA, oMacB, oMAC, oRET, oResValid, oRes
    );
endinterface

// File: rtl/dot_product_sequencer_operand_fifo.sv
// rtl/dot_product_sequencer_operand_fifo.sv - operand pair buffer with wrap-bit pointers
module operand_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic             push_ok, pop_ok;

    // Full/empty come from pre-update pointers, so a push is refused when full even if a pop frees a slot
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
endmodule

// File: rtl/dot_product_sequencer.sv
// rtl/dot_product_sequencer.sv - buffers operand pairs, drives MAC/return pulses, holds the final sum
module dot_product_sequencer
    import dot_product_sequencer_pkg::*;
#(
    parameter int INPUT_LENGTH  = DPS_INPUT_LENGTH,
    parameter int OUTPUT_LENGTH = DPS_OUTPUT_LENGTH,
    parameter int LEN_WIDTH     = DPS_LEN_WIDTH,
    parameter int FIFO_DEPTH    = DPS_FIFO_DEPTH
) (
    input  logic iClk,
    input  logic iRst,
    dot_product_sequencer_if.master bus
);
    localparam int PAIR_W = 2 * INPUT_LENGTH;

    state_e                   state_q, state_d;
    logic [LEN_WIDTH-1:0]     len_q, len_d;
    logic [LEN_WIDTH-1:0]     acc_q, acc_d;
    logic [LEN_WIDTH-1:0]     iss_q, iss_d;
    logic [OUTPUT_LENGTH-1:0] res_q, res_d;
    logic                     res_valid_q, res_valid_d;

    logic              fifo_full, fifo_empty, fifo_push;
    logic [PAIR_W-1:0] fifo_head;
    logic              op_ready, mac_fire, ret_fire;

    operand_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_operand_fifo (
        .clk_i   (iClk),
        .rst_ni  (iRst),
        .push_i  (fifo_push),
        .wdata_i ({bus.iOpA, bus.iOpB}),
        .pop_i   (mac_fire),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        acc_d       = acc_q;
        iss_d       = iss_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        op_ready    = 1'b0;
        fifo_push   = 1'b0;
        mac_fire    = 1'b0;
        ret_fire    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.iStart) begin
                    len_d = bus.iLen;
                    acc_d = '0;
                    iss_d = '0;
                    // An empty job skips the MAC entirely and reports a zero sum
                    if (bus.iLen == '0) begin
                        res_d       = '0;
                        res_valid_d = 1'b1;
                        state_d     = ST_HOLD;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                op_ready  = !fifo_full && (acc_q < len_q);
                fifo_push = op_ready && bus.iOpValid;
                mac_fire  = !fifo_empty && bus.iMacReady;
                if (fifo_push) acc_d = acc_q + LEN_WIDTH'(1);
                if (mac_fire) begin
                    iss_d = iss_q + LEN_WIDTH'(1);
                    if (iss_q + LEN_WIDTH'(1) == len_q) state_d = ST_RET;
                end
            end
            ST_RET: begin
                ret_fire = bus.iMacReady;
                if (bus.iMacReady) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.iMacDone) begin
                    res_d       = bus.iMacRes;
                    res_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.iResReady) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            acc_q       <= '0;
            iss_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            acc_q       <= acc_d;
            iss_q       <= iss_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign bus.oBusy     = (state_q != ST_IDLE);
    assign bus.oOpReady  = op_ready;
    assign bus.oMAC      = mac_fire;
    assign bus.oRET      = ret_fire;
    assign bus.oMacA     = fifo_head[PAIR_W-1:INPUT_LENGTH];
    assign bus.oMacB     = fifo_head[INPUT_LENGTH-1:0];
    assign bus.oResValid = res_valid_q;
    assign bus.oRes      = res_q;
endmodule

// File: tb/tb_dot_product_sequencer.sv
// tb/tb_dot_product_sequencer.sv - randomized bench with operand source, MAC model and sum reference
module tb_dot_product_sequencer;
    import dot_product_sequencer_pkg::*;

    logic iClk = 1'b0;
    logic iRst = 1'b0;

    dot_product_sequencer_if bus ();

    dot_product_sequencer dut (
        .iClk (iClk),
        .iRst (iRst),
        .bus  (bus)
    );

    always #5 iClk = ~iClk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Operand source: a job consumes the next len pairs of this stream
    int src_a[$];
    int src_b[$];
    int acc_cnt   = 0;
    bit gap_mode  = 1'b0;

    // MAC model state
    longint mac_sum   = 0;
    int     mac_cnt   = 0;
    int     ret_cnt   = 0;
    int     proto_bad = 0;
    int     mac_lat   = 1;
    int     countdown = 0;
    int     ready_mode = 0;

    longint exp_sum;
    longint held;

    initial begin
        bus.iOpValid = 1'b0;
        bus.iOpA     = '0;
        bus.iOpB     = '0;
        forever begin
            @(posedge iClk);
            if (iRst && bus.iOpValid && bus.oOpReady) begin
                src_a.delete(0);
                src_b.delete(0);
                acc_cnt++;
            end
            #1;
            if (src_a.size() > 0 && (!gap_mode || $urandom_range(0, 3) != 0)) begin
                bus.iOpValid = 1'b1;
                bus.iOpA     = src_a[0];
                bus.iOpB     = src_b[0];
            end else begin
                bus.iOpValid = 1'b0;
            end
        end
    end

    initial begin
        bus.iMacDone  = 1'b0;
        bus.iMacRes   = '0;
        bus.iMacReady = 1'b0;
        forever begin
            @(posedge iClk);
            if (!iRst) begin
                mac_sum   = 0;
                countdown = 0;
            end else begin
                if (bus.oMAC) begin
                    if (!bus.iMacReady) proto_bad++;
                    mac_sum += longint'($signed(bus.oMacA)) * longint'($signed(bus.oMacB));
                    mac_cnt++;
                end
                if (bus.oRET) begin
                    if (!bus.iMacReady) proto_bad++;
                    ret_cnt++;
                    countdown = mac_lat;
                end
            end
            #1;
            bus.iMacDone = 1'b0;
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    bus.iMacDone = 1'b1;
                    bus.iMacRes  = mac_sum;
                    mac_sum      = 0;
                end
            end
            case (ready_mode)
                0:       bus.iMacReady = 1'b0;
                1:       bus.iMacReady = 1'b1;
                default: bus.iMacReady = 1'($urandom_range(0, 1));
            endcase
        end
    end

    function automatic longint model_sum(input int n);
        longint s = 0;
        for (int i = 0; i < n; i++) s += longint'(src_a[i]) * longint'(src_b[i]);
        return s;
    endfunction

    task automatic load_pair(input int a, input int b);
        src_a.push_back(a);
        src_b.push_back(b);
    endtask

    task automatic load_random(input int n);
        for (int i = 0; i < n; i++) load_pair(int'($urandom), int'($urandom));
    endtask

    task automatic start_job(input len_t len);
        exp_sum = model_sum(int'(len));
        mac_cnt = 0;
        ret_cnt = 0;
        acc_cnt = 0;
        @(posedge iClk);
        #1;
        bus.iStart = 1'b1;
        bus.iLen   = len;
        @(posedge iClk);
        #1;
        bus.iStart = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int n = 0;
        do begin
            @(negedge iClk);
            n++;
        end while (!bus.oResValid && n < 2000);
        check_eq({tag, "_res_valid"}, longint'(bus.oResValid), 1);
    endtask

    task automatic release_result(input string tag);
        bus.iResReady = 1'b1;
        @(posedge iClk);
        #1;
        bus.iResReady = 1'b0;
        @(negedge iClk);
        check_eq({tag, "_idle_busy"}, longint'(bus.oBusy), 0);
        check_eq({tag, "_idle_valid"}, longint'(bus.oResValid), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.iStart    = 1'b0;
        bus.iLen      = '0;
        bus.iResReady = 1'b0;
        repeat (3) @(negedge iClk);
        check_eq("rst_busy",  longint'(bus.oBusy), 0);
        check_eq("rst_opr",   longint'(bus.oOpReady), 0);
        check_eq("rst_mac",   longint'(bus.oMAC), 0);
        check_eq("rst_ret",   longint'(bus.oRET), 0);
        check_eq("rst_valid", longint'(bus.oResValid), 0);
        check_eq("rst_res",   longint'(bus.oRes), 0);
        iRst = 1'b1;

        // Fixed three-pair job
        ready_mode = 1;
        mac_lat    = 2;
        load_pair(2, 3);
        load_pair(-4, 5);
        load_pair(7, -1);
        start_job(3);
        wait_result("t1");
        check_eq("t1_res",   longint'($signed(bus.oRes)), -21);
        check_eq("t1_model", longint'($signed(bus.oRes)), exp_sum);
        check_eq("t1_macs",  mac_cnt, 3);
        check_eq("t1_rets",  ret_cnt, 1);
        repeat (3) @(negedge iClk);
        check_eq("t1_held",  longint'(bus.oResValid), 1);
        release_result("t1");

        // Empty job
        start_job(0);
        @(negedge iClk);
        check_eq("t2_valid", longint'(bus.oResValid), 1);
        check_eq("t2_res",   longint'(bus.oRes), 0);
        check_eq("t2_busy",  longint'(bus.oBusy), 1);
        check_eq("t2_macs",  mac_cnt, 0);
        check_eq("t2_rets",  ret_cnt, 0);
        release_result("t2");

        // MAC stalled: buffer fills and back-pressures
        ready_mode = 0;
        load_random(6);
        start_job(6);
        repeat (10) @(negedge iClk);
        check_eq("t3_accepted", acc_cnt, 4);
        check_eq("t3_opready",  longint'(bus.oOpReady), 0);
        check_eq("t3_macs_stall", mac_cnt, 0);
        ready_mode = 1;
        wait_result("t3");
        check_eq("t3_res",  longint'($signed(bus.oRes)), exp_sum);
        check_eq("t3_macs", mac_cnt, 6);
        check_eq("t3_acc",  acc_cnt, 6);
        release_result("t3");

        // Excess pairs stay queued; restart during RUN ignored
        load_random(5);
        start_job(2);
        bus.iStart = 1'b1;
        bus.iLen   = 7;
        @(posedge iClk);
        #1;
        bus.iStart = 1'b0;
        wait_result("t4a");
        check_eq("t4a_res",  longint'($signed(bus.oRes)), exp_sum);
        check_eq("t4a_acc",  acc_cnt, 2);
        check_eq("t4a_macs", mac_cnt, 2);
        release_result("t4a");
        check_eq("t4_left", src_a.size(), 3);
        start_job(3);
        wait_result("t4b");
        check_eq("t4b_res", longint'($signed(bus.oRes)), exp_sum);
        release_result("t4b");
        check_eq("t4_drained", src_a.size(), 0);

        // Result held while consumer stalls; start requests ignored
        ready_mode = 2;
        load_random(1);
        start_job(1);
        wait_result("t5");
        held = exp_sum;
        bus.iStart = 1'b1;
        bus.iLen   = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge iClk);
            check_eq("t5_res",   longint'($signed(bus.oRes)), held);
            check_eq("t5_busy",  longint'(bus.oBusy), 1);
            check_eq("t5_valid", longint'(bus.oResValid), 1);
        end
        bus.iStart = 1'b0;
        release_result("t5");
        @(negedge iClk);
        check_eq("t5_no_new_job", longint'(bus.oBusy), 0);

        // Reset while waiting on the MAC
        ready_mode = 1;
        mac_lat    = 8;
        load_random(2);
        start_job(2);
        for (int n = 0; n < 200 && ret_cnt == 0; n++) @(negedge iClk);
        check_eq("t6_ret_seen", ret_cnt, 1);
        @(negedge iClk);
        iRst = 1'b0;
        #1;
        check_eq("t6_busy",  longint'(bus.oBusy), 0);
        check_eq("t6_opr",   longint'(bus.oOpReady), 0);
        check_eq("t6_mac",   longint'(bus.oMAC), 0);
        check_eq("t6_ret",   longint'(bus.oRET), 0);
        check_eq("t6_valid", longint'(bus.oResValid), 0);
        check_eq("t6_res",   longint'(bus.oRes), 0);
        check_eq("t6_maca",  longint'(bus.oMacA), 0);
        check_eq("t6_macb",  longint'(bus.oMacB), 0);
        repeat (2) @(negedge iClk);
        src_a.delete();
        src_b.delete();
        iRst    = 1'b1;
        mac_lat = 2;
        load_pair(5, 5);
        start_job(1);
        wait_result("t6");
        check_eq("t6_res25", longint'($signed(bus.oRes)), 25);
        check_eq("t6_macs",  mac_cnt, 1);
        release_result("t6");

        // Random jobs with operand gaps and MAC ready toggling
        ready_mode = 2;
        gap_mode   = 1'b1;
        for (int j = 0; j < 8; j++) begin
            int len;
            len     = $urandom_range(1, 10);
            mac_lat = $urandom_range(1, 4);
            load_random(len + $urandom_range(0, 2));
            start_job(len_t'(len));
            wait_result("rnd");
            check_eq("rnd_res",  longint'($signed(bus.oRes)), exp_sum);
            check_eq("rnd_macs", mac_cnt, len);
            check_eq("rnd_rets", ret_cnt, 1);
            release_result("rnd");
        end

        check_eq("mac_ready_protocol", proto_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
